// File: rtl/mmreq_bridge.sv
// mmreq_bridge: turns Xillybus mmreq words into strobe/ack register transactions and returns read data on mmresp.
// Read header-to-response is at least 3 cycles. It stalls on an empty mmreq or a full mmresp, and drops the response if mmresp is closed.
`timescale 1ns/1ps
module mmreq_bridge #(
  parameter int          ADDR_W         = 20,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_VALUE  = 32'hDEADBEEF
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              mmreq_open,
  input  logic [31:0]       mmreq_dout,
  input  logic              mmreq_empty,
  output logic              mmreq_rden,
  input  logic              mmresp_open,
  output logic [31:0]       mmresp_din,
  output logic              mmresp_wren,
  input  logic              mmresp_full,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic              reg_ack,
  input  logic [31:0]       reg_rdata,
  output logic [7:0]        timeout_cnt,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_DATA,
    S_WRITE,
    S_READ,
    S_RESP
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] tcnt;
  logic        strobe_last;

  assign strobe_last = (tcnt == TO_LAST);

  // FIFO handshakes are gated by reset so nothing is popped or pushed while the bridge is held.
  assign mmreq_rden  = !bus_rst && mmreq_open && !mmreq_empty &&
                       (state == S_IDLE || state == S_GET_DATA);
  assign mmresp_wren = !bus_rst && (state == S_RESP) && mmresp_open && !mmresp_full;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state       <= S_IDLE;
      tcnt        <= 16'd0;
      reg_addr    <= '0;
      reg_wdata   <= 32'd0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      mmresp_din  <= 32'd0;
      timeout_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mmreq_rden) begin
            reg_addr <= mmreq_dout[ADDR_W-1:0];
            tcnt     <= 16'd0;
            if (mmreq_dout[31]) begin
              state <= S_GET_DATA;
            end else begin
              state  <= S_READ;
              reg_rd <= 1'b1;
            end
          end
        end
        S_GET_DATA: begin
          if (mmreq_rden) begin
            reg_wdata <= mmreq_dout;
            tcnt      <= 16'd0;
            reg_wr    <= 1'b1;
            state     <= S_WRITE;
          end else if (!mmreq_open) begin
            state <= S_IDLE;
          end
        end
        S_WRITE: begin
          tcnt <= tcnt + 16'd1;
          if (reg_ack || strobe_last) begin
            reg_wr <= 1'b0;
            state  <= S_IDLE;
            if (!reg_ack && timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
          end
        end
        S_READ: begin
          tcnt <= tcnt + 16'd1;
          if (reg_ack || strobe_last) begin
            reg_rd     <= 1'b0;
            state      <= S_RESP;
            mmresp_din <= reg_ack ? reg_rdata : TIMEOUT_VALUE;
            if (!reg_ack && timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
          end
        end
        S_RESP: begin
          // A closed mmresp drops the word so a host close cannot wedge the bridge.
          if (!mmresp_open || !mmresp_full) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmreq_bridge.sv
// Randomized bench for mmreq_bridge: FIFO and register-slave models plus a transaction-level scoreboard.
`timescale 1ns/1ps
module tb_mmreq_bridge;

  localparam int          AW  = 20;
  localparam int          TO  = 8;
  localparam logic [31:0] TOV = 32'hDEADBEEF;

  logic          bus_clk = 1'b0;
  logic          bus_rst = 1'b1;
  logic          mmreq_open = 1'b1;
  logic [31:0]   mmreq_dout = 32'd0;
  logic          mmreq_empty = 1'b1;
  logic          mmreq_rden;
  logic          mmresp_open = 1'b1;
  logic [31:0]   mmresp_din;
  logic          mmresp_wren;
  logic          mmresp_full = 1'b0;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wdata;
  logic          reg_wr;
  logic          reg_rd;
  logic          reg_ack = 1'b0;
  logic [31:0]   reg_rdata = 32'd0;
  logic [7:0]    timeout_cnt;
  logic          busy;

  mmreq_bridge #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO), .TIMEOUT_VALUE(TOV)) dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst),
    .mmreq_open(mmreq_open), .mmreq_dout(mmreq_dout), .mmreq_empty(mmreq_empty), .mmreq_rden(mmreq_rden),
    .mmresp_open(mmresp_open), .mmresp_din(mmresp_din), .mmresp_wren(mmresp_wren), .mmresp_full(mmresp_full),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .timeout_cnt(timeout_cnt), .busy(busy)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            len;
  } bus_rec_t;

  logic [31:0] req_q[$];
  int          sl_delay_q[$];
  logic [31:0] sl_data_q[$];
  bus_rec_t    obs_q[$];
  bus_rec_t    exp_bus_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_resp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int exp_to   = 0;
  int ovl_err  = 0;
  int stab_err = 0;
  int rden_err = 0;
  int wren_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Request FIFO read side (FWFT): head word presented shortly after each falling edge.
  initial forever begin
    @(negedge bus_clk); #1;
    mmreq_empty = (req_q.size() == 0);
    mmreq_dout  = (req_q.size() != 0) ? req_q[0] : 32'd0;
  end

  // Register slave: acks after a per-transaction delay (0 = never) and records each strobe.
  initial begin : slave
    bus_rec_t    cur;
    bit          in_str;
    int          cur_delay;
    logic [31:0] cur_rdata;
    in_str = 0;
    cur_delay = 0;
    cur_rdata = 32'd0;
    cur = '{0, '0, 32'd0, 0};
    forever begin
      @(negedge bus_clk); #1;
      reg_ack   = 1'b0;
      reg_rdata = $urandom;
      if (reg_rd && reg_wr) ovl_err++;
      if (reg_rd || reg_wr) begin
        if (!in_str) begin
          in_str    = 1;
          cur.wr    = reg_wr;
          cur.addr  = reg_addr;
          cur.data  = reg_wr ? reg_wdata : 32'd0;
          cur.len   = 0;
          cur_delay = (sl_delay_q.size() != 0) ? sl_delay_q.pop_front() : 1;
          cur_rdata = (sl_data_q.size() != 0) ? sl_data_q.pop_front() : 32'd0;
        end else if (reg_addr !== cur.addr || bit'(reg_wr) != cur.wr ||
                     (cur.wr && reg_wdata !== cur.data)) begin
          stab_err++;
        end
        cur.len++;
        if (cur.len == cur_delay) begin
          reg_ack   = 1'b1;
          reg_rdata = cur_rdata;
        end
      end else if (in_str) begin
        in_str = 0;
        obs_q.push_back(cur);
      end
    end
  end

  // FIFO-side monitor sampled just before the rising edge.
  initial forever begin
    @(negedge bus_clk); #3;
    if (mmreq_rden) begin
      if (mmreq_empty || req_q.size() == 0) rden_err++;
      else void'(req_q.pop_front());
    end
    if (mmresp_wren) begin
      if (mmresp_full || !mmresp_open) wren_err++;
      got_q.push_back(mmresp_din);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit timed_out(input int delay);
    return !(delay >= 1 && delay <= TO);
  endfunction

  task automatic issue_read(input logic [AW-1:0] addr, input int delay, input logic [31:0] data,
                            input logic [10:0] junk, input bit expect_resp);
    bus_rec_t r;
    req_q.push_back({1'b0, junk, addr});
    sl_delay_q.push_back(delay);
    sl_data_q.push_back(data);
    r.wr = 0; r.addr = addr; r.data = 32'd0;
    r.len = timed_out(delay) ? TO : delay;
    exp_bus_q.push_back(r);
    if (expect_resp) exp_resp_q.push_back(timed_out(delay) ? TOV : data);
    if (timed_out(delay) && exp_to < 255) exp_to++;
  endtask

  task automatic issue_write(input logic [AW-1:0] addr, input logic [31:0] wdata, input int delay,
                             input logic [10:0] junk);
    bus_rec_t r;
    req_q.push_back({1'b1, junk, addr});
    req_q.push_back(wdata);
    sl_delay_q.push_back(delay);
    sl_data_q.push_back(32'd0);
    r.wr = 1; r.addr = addr; r.data = wdata;
    r.len = timed_out(delay) ? TO : delay;
    exp_bus_q.push_back(r);
    if (timed_out(delay) && exp_to < 255) exp_to++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge bus_clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 20000) begin
      @(negedge bus_clk); #4;
      if (!busy && req_q.size() == 0) quiet++;
      else quiet = 0;
      n++;
    end
    check({tag, " idle"}, 64'(quiet >= 3), 64'd1);
  endtask

  task automatic scoreboard(input string tag);
    bus_rec_t o, e;
    check({tag, " bus count"}, obs_q.size(), exp_bus_q.size());
    while (obs_q.size() != 0 && exp_bus_q.size() != 0) begin
      o = obs_q.pop_front();
      e = exp_bus_q.pop_front();
      check({tag, " bus txn"}, {o.wr, o.addr, o.data, 10'(o.len)}, {e.wr, e.addr, e.data, 10'(e.len)});
    end
    check({tag, " resp count"}, got_q.size(), exp_resp_q.size());
    while (got_q.size() != 0 && exp_resp_q.size() != 0)
      check({tag, " resp word"}, got_q.pop_front(), exp_resp_q.pop_front());
    check({tag, " timeout_cnt"}, timeout_cnt, exp_to);
    obs_q.delete(); exp_bus_q.delete(); got_q.delete(); exp_resp_q.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " ctrl"}, {reg_rd, reg_wr, mmresp_wren, mmreq_rden, busy}, 0);
    check({tag, " reg_addr"}, reg_addr, 0);
    check({tag, " reg_wdata"}, reg_wdata, 0);
    check({tag, " mmresp_din"}, mmresp_din, 0);
    check({tag, " timeout_cnt"}, timeout_cnt, 0);
  endtask

  initial begin
    logic [31:0] held;
    cyc(3); #3;
    check_reset_outs("reset");
    @(negedge bus_clk) bus_rst = 1'b0;

    issue_read(20'h00123, 3, 32'hCAFEF00D, 11'd0, 1);
    wait_idle("read");
    scoreboard("read");

    issue_write(20'h00040, 32'h12345678, 1, 11'd0);
    wait_idle("write");
    scoreboard("write");

    issue_read(20'h0ABCD, 0, 32'h11111111, 11'($urandom), 1);
    issue_read(20'h0ABCE, TO, 32'h5A5A1234, 11'($urandom), 1);
    wait_idle("timeout");
    scoreboard("timeout");

    // Write header with no data word behind it, then the host closes mmreq.
    req_q.push_back(32'h80000077);
    cyc(22); #3;
    check("getdata busy", busy, 1);
    check("getdata no strobe", {reg_wr, reg_rd}, 0);
    @(negedge bus_clk) mmreq_open = 1'b0;
    issue_read(20'h00777, 2, 32'h0F0F0F0F, 11'($urandom), 1);
    cyc(5); #3;
    check("closed idle", busy, 0);
    check("closed no pop", req_q.size(), 1);
    @(negedge bus_clk) mmreq_open = 1'b1;
    wait_idle("reopen");
    scoreboard("reopen");

    @(negedge bus_clk) mmresp_full = 1'b1;
    issue_read(20'h00321, 2, 32'h0BADCAFE, 11'($urandom), 1);
    cyc(15); #3;
    check("full no push", got_q.size(), 0);
    check("full busy", busy, 1);
    held = mmresp_din;
    check("full din", held, 32'h0BADCAFE);
    cyc(10); #3;
    check("full din stable", mmresp_din, held);
    @(negedge bus_clk) mmresp_full = 1'b0;
    wait_idle("full");
    scoreboard("full");

    @(negedge bus_clk) mmresp_open = 1'b0;
    issue_read(20'h00322, 1, 32'h87654321, 11'($urandom), 0);
    wait_idle("resp closed");
    scoreboard("resp closed");
    @(negedge bus_clk) mmresp_open = 1'b1;

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1)
        issue_write(AW'($urandom), $urandom, $urandom_range(0, 10), 11'($urandom));
      else
        issue_read(AW'($urandom), $urandom_range(0, 10), $urandom, 11'($urandom), 1);
    end
    wait_idle("random");
    scoreboard("random");

    for (int i = 0; i < 300; i++) begin
      if (i % 3 == 0) issue_write(AW'($urandom), $urandom, 0, 11'($urandom));
      else            issue_read(AW'($urandom), 0, $urandom, 11'($urandom), 1);
    end
    wait_idle("saturate");
    scoreboard("saturate");

    // Reset in the middle of a read that would otherwise time out.
    req_q.push_back(32'h00000555);
    sl_delay_q.push_back(0);
    sl_data_q.push_back(32'd0);
    cyc(4); #3;
    check("pre-reset rd", reg_rd, 1);
    @(negedge bus_clk) bus_rst = 1'b1;
    @(posedge bus_clk); #3;
    check_reset_outs("mid reset");
    cyc(2);
    bus_rst = 1'b0;
    cyc(5); #3;
    check("no push after reset", got_q.size(), 0);
    obs_q.delete();
    exp_to = 0;
    issue_read(20'h00999, 2, 32'h13579BDF, 11'($urandom), 1);
    wait_idle("post reset");
    scoreboard("post reset");

    check("strobe overlap", ovl_err, 0);
    check("strobe stability", stab_err, 0);
    check("rden while empty", rden_err, 0);
    check("wren while full/closed", wren_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmreq_bridge.md
# mmreq_bridge

Register-access bridge directly downstream of the Xillybus core's `mmreq` host-to-FPGA stream and upstream of its `mmresp` FPGA-to-host stream. It pops 32-bit request words from the `mmreq` FIFO read side and parses them into single read/write transactions. Each transaction runs on a simple strobe/ack register bus with a timeout. Read results are pushed into the `mmresp` FIFO write side.

## Interface
Parameters:
- `ADDR_W`, 20: register bus address width. Taken from header bits [ADDR_W-1:0]; ADDR_W ≤ 24.
- `TIMEOUT_CYCLES`, 1024: cycles a strobe may stay high without ack; range 2..65535.
- `TIMEOUT_VALUE`, 32'hDEADBEEF: data returned for a timed-out read.

Ports:
- `bus_clk`  in  1  sole clock, same domain as the Xillybus user streams.
- `bus_rst`  in  1  synchronous, active-high reset.
- `mmreq_open`  in  1  host has the `mmreq` device open.
- `mmreq_dout`  in  32  FWFT FIFO head word; valid while `mmreq_empty`=0.
- `mmreq_empty`  in  1  request FIFO empty.
- `mmreq_rden`  out  1  pop the head word; asserted only when `mmreq_empty`=0.
- `mmresp_open`  in  1  host has the `mmresp` device open.
- `mmresp_din`  out  32  response word.
- `mmresp_wren`  out  1  push `mmresp_din`; asserted only when `mmresp_full`=0.
- `mmresp_full`  in  1  response FIFO full.
- `reg_addr`  out  ADDR_W  register address; held for the whole transaction.
- `reg_wdata`  out  32  write data.
- `reg_wr`  out  1  write strobe; level, held until ack or timeout.
- `reg_rd`  out  1  read strobe; level, held until ack or timeout.
- `reg_ack`  in  1  single-cycle completion.
- `reg_rdata`  in  32  read data; valid with `reg_ack` on reads.
- `timeout_cnt`  out  8  saturating count of timed-out transactions.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Header word: bit31 = 1 for write, 0 for read. Bits [ADDR_W-1:0] = address. Bits [30:ADDR_W] are ignored.
- A write request is a header followed by one data word. A read request is the header alone.
- States:
  - IDLE → (pop header) → GET_DATA if write, READ if read.
  - GET_DATA → (pop data word) → WRITE.
  - WRITE → (ack or timeout) → IDLE.
  - READ → (ack: capture `reg_rdata`; timeout: capture TIMEOUT_VALUE) → RESP.
  - RESP → (push one word) → IDLE.
- Writes produce no response word. Each read produces exactly one response word.
- Timeout counter: 16-bit. Cleared on entering WRITE/READ and incremented each cycle a strobe is high. When it reaches TIMEOUT_CYCLES-1 with no ack that cycle:
  - the strobe drops next cycle;
  - `timeout_cnt` increments, saturating at 255.
- Ack and timeout in the same cycle: ack wins and `timeout_cnt` is unchanged.
- `reg_ack` is ignored in IDLE, GET_DATA and RESP.
- `mmreq_open`=0:
  - In GET_DATA, the held header is discarded and the state returns to IDLE.
  - In IDLE, no pops occur.
  - An in-flight WRITE/READ completes normally.
- `mmresp_open`=0 in RESP: the word is dropped without asserting wren, and the state returns to IDLE. This prevents deadlock after a host close.
- Reset values: state IDLE, all strobes/wren/rden 0, `reg_addr`/`reg_wdata`/`mmresp_din` 0, timeout counter 0, `timeout_cnt` 0, `busy` 0.

## Timing
- `mmreq_rden` is combinational from state, `mmreq_empty` and `mmreq_open`. The popped word is registered on the same edge.
- Read latency, with the header popped in cycle 0:
  - `reg_rd` high cycles 1..k, where `reg_ack` arrives in cycle k.
  - RESP in cycle k+1; `mmresp_wren` asserted there if not full.
  - IDLE in cycle k+2.
  - Minimum header-to-response is 3 cycles with k=1.
- Write latency, with the header popped in cycle 0 and data in cycle d ≥ 1: `reg_wr` high from cycle d+1.
- Back-to-back: the next header can pop in the cycle after return to IDLE.
- `mmresp_full`=1 in RESP: hold `mmresp_din`, wren stays 0, wait indefinitely.
- Strobes never overlap. `reg_addr` and `reg_wdata` are stable while a strobe is high.
- Reset asserted mid-transaction: the strobe drops on the next edge and no response is pushed. Partial requests still in the FIFO are the host's responsibility.

## Test plan
- Read with ack 3 cycles after strobe: header 0x00000123, reg_rdata 0xCAFEF00D → `reg_rd` high for exactly 3 cycles with reg_addr 0x00123, then one push of 0xCAFEF00D.
- Write: words 0x80000040, 0x12345678, ack after 1 cycle → one `reg_wr` pulse with addr 0x00040 and data 0x12345678, no mmresp push.
- Read timeout with TIMEOUT_CYCLES=8 and no ack → `reg_rd` high exactly 8 cycles, push 0xDEADBEEF, `timeout_cnt`=1. Ack in the 8th cycle → real data returned, `timeout_cnt` unchanged.
- Write header, then `mmreq_empty` held 20 cycles → stays in GET_DATA with no strobe. Deassert `mmreq_open` → IDLE and the header is discarded. A subsequent read works normally.
- Read completes while `mmresp_full`=1 for 10 cycles → wren stays 0 and din stable, then exactly one push. A repeat with `mmresp_open`=0 → no push and a return to IDLE.
- Four mixed back-to-back requests with FIFO always non-empty → order preserved, 300 timeouts saturate `timeout_cnt` at 255, and reset mid-READ clears every output within one cycle.
